// File: rtl/joypad_pkg.sv
// Shared constants for the joypad input conditioner: button order and register offsets.
package joypad_pkg;
  localparam int JOY_WIDTH  = 5;
  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_UP     = 2;
  localparam int JOY_DOWN   = 3;
  localparam int JOY_ACTION = 4;

  localparam logic JOY_REG_LEVEL = 1'b0;
  localparam logic JOY_REG_EVENT = 1'b1;
endpackage

// File: rtl/debounce_cell.sv
// One-bit debouncer: 2-FF synchronizer, hold counter and accepted level, plus a
// combinational rise flag that is high in the cycle before level goes 0->1.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o
);
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    // Any sample that agrees with the accepted level restarts the hold window.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_d & ~level_q;
endmodule

// File: rtl/joypad_debouncer.sv
// Joypad conditioner: five debounce cells, sticky W1C press-event latches,
// level/event read mux and a registered interrupt.
module joypad_debouncer
  import joypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [JOY_WIDTH-1:0] joypad_raw,
  input  logic                 addr,
  input  logic [JOY_WIDTH-1:0] wdata,
  input  logic                 wenable,
  output logic [31:0]          rdata,
  output logic                 irq
);
  logic [JOY_WIDTH-1:0] pin, level, rise, clr;
  logic [JOY_WIDTH-1:0] evt_q, evt_d;
  logic                 irq_q, irq_d;

  // Polarity is normalised before the synchronizer so "1" always means pressed.
  assign pin = joypad_raw ^ {JOY_WIDTH{ACTIVE_LOW != 0}};

  for (genvar i = 0; i < JOY_WIDTH; i++) begin : g_cell
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin_i   (pin[i]),
      .level_o (level[i]),
      .rise_o  (rise[i])
    );
  end

  always_comb begin
    clr   = (wenable && addr == JOY_REG_EVENT) ? wdata : '0;
    // A press landing on the same edge as its clear must not be lost.
    evt_d = (evt_q & ~clr) | rise;
    irq_d = |evt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
      irq_q <= irq_d;
    end
  end

  assign rdata = (addr == JOY_REG_EVENT) ? {{(32-JOY_WIDTH){1'b0}}, evt_q}
                                         : {{(32-JOY_WIDTH){1'b0}}, level};
  assign irq   = irq_q;
endmodule

// File: tb/tb_joypad_debouncer.sv
// Bench for joypad_debouncer: expected register/irq values are queued with the
// cycle they are due on and compared when the bench reaches that cycle.
module tb_joypad_debouncer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  raw0 = 5'h00, raw1 = 5'h1F, wdata = 5'h00;
  logic        addr = 1'b0, wen0 = 1'b0, wen1 = 1'b0;
  logic [31:0] rdata0, rdata1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         due;
    string      tag;
    bit         dut;
    logic [4:0] lvl;
    logic [4:0] evt;
    logic       irq;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  joypad_debouncer #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .joypad_raw(raw0), .addr(addr),
    .wdata(wdata), .wenable(wen0), .rdata(rdata0), .irq(irq0)
  );

  joypad_debouncer #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .joypad_raw(raw1), .addr(addr),
    .wdata(wdata), .wenable(wen1), .rdata(rdata1), .irq(irq1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_at(input int dly, input string tag, input bit d,
                           input logic [4:0] l, input logic [4:0] e, input logic i);
    exp_t x;
    x.due = cyc + dly; x.tag = tag; x.dut = d; x.lvl = l; x.evt = e; x.irq = i;
    sbq.push_back(x);
  endtask

  // Reads both registers through the shared address line, then parks it at 0.
  task automatic sample(input bit d, output logic [31:0] l, output logic [31:0] e,
                        output logic i);
    addr = 1'b0; #1;
    l = d ? rdata1 : rdata0;
    addr = 1'b1; #1;
    e = d ? rdata1 : rdata0;
    i = d ? irq1 : irq0;
    addr = 1'b0;
  endtask

  task automatic drain();
    logic [31:0] l, e;
    logic        i;
    int k = 0;
    while (k < sbq.size()) begin
      if (sbq[k].due == cyc) begin
        sample(sbq[k].dut, l, e, i);
        chk({sbq[k].tag, "_lvl"}, l, {27'b0, sbq[k].lvl});
        chk({sbq[k].tag, "_evt"}, e, {27'b0, sbq[k].evt});
        chk({sbq[k].tag, "_irq"}, {31'b0, i}, {31'b0, sbq[k].irq});
        sbq.delete(k);
      end else begin
        k++;
      end
    end
  endtask

  // Advance n edges; write strobes last exactly one edge.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      wen0 = 1'b0; wen1 = 1'b0; addr = 1'b0;
      cyc++;
      drain();
    end
  endtask

  task automatic wr(input bit d, input logic a, input logic [4:0] data);
    addr = a; wdata = data;
    if (d) wen1 = 1'b1; else wen0 = 1'b1;
    run(1);
  endtask

  initial begin
    run(2);
    expect_at(0, "por", 1'b0, 5'h00, 5'h00, 1'b0);
    drain();
    rst_n = 1'b1;

    // Hold all buttons, then hit reset away from any clock edge.
    raw0 = 5'h1F;
    expect_at(6, "hold_all", 1'b0, 5'h1F, 5'h1F, 1'b1);
    run(10);
    #2 rst_n = 1'b0;
    #1;
    expect_at(0, "async_rst", 1'b0, 5'h00, 5'h00, 1'b0);
    drain();
    run(2);
    rst_n = 1'b1;
    expect_at(5, "rst_rel_e5", 1'b0, 5'h00, 5'h00, 1'b0);
    expect_at(6, "rst_rel_e6", 1'b0, 5'h1F, 5'h1F, 1'b1);
    run(6);

    // Clear everything, release, releases must not raise events.
    wr(1'b0, 1'b1, 5'h1F);
    raw0 = 5'h00;
    expect_at(5, "rel_e5", 1'b0, 5'h1F, 5'h00, 1'b0);
    expect_at(6, "rel_e6", 1'b0, 5'h00, 5'h00, 1'b0);
    run(8);

    // Glitch on bit 2 for 3 cycles is shorter than the hold window.
    raw0 = 5'h04;
    for (int t = 1; t <= 10; t++) expect_at(t, "glitch", 1'b0, 5'h00, 5'h00, 1'b0);
    run(3);
    raw0 = 5'h00;
    run(7);

    // Press action, clear its event, release.
    raw0 = 5'h10;
    expect_at(5, "act_e5", 1'b0, 5'h00, 5'h00, 1'b0);
    expect_at(6, "act_e6", 1'b0, 5'h10, 5'h10, 1'b1);
    run(6);
    wr(1'b0, 1'b1, 5'h10);
    expect_at(0, "act_clr", 1'b0, 5'h10, 5'h00, 1'b0);
    drain();
    raw0 = 5'h00;
    expect_at(5, "act_rel5", 1'b0, 5'h10, 5'h00, 1'b0);
    expect_at(6, "act_rel6", 1'b0, 5'h00, 5'h00, 1'b0);
    run(8);

    // Clear of bit 0 on the very edge it is accepted: the set wins.
    raw0 = 5'h01;
    run(5);
    wr(1'b0, 1'b1, 5'h01);
    expect_at(0, "collide", 1'b0, 5'h01, 5'h01, 1'b1);
    drain();

    // Clearing bit 1 leaves bit 0 pending.
    raw0 = 5'h03;
    expect_at(6, "two_set", 1'b0, 5'h03, 5'h03, 1'b1);
    run(6);
    wr(1'b0, 1'b1, 5'h02);
    expect_at(0, "part_clr", 1'b0, 5'h03, 5'h01, 1'b1);
    drain();

    // Active-low instance: idle-high pins are not presses.
    expect_at(0, "al_idle", 1'b1, 5'h00, 5'h00, 1'b0);
    drain();
    raw1 = 5'h17;
    expect_at(5, "al_dn5", 1'b1, 5'h00, 5'h00, 1'b0);
    expect_at(6, "al_dn6", 1'b1, 5'h08, 5'h08, 1'b1);
    run(6);
    wr(1'b1, 1'b0, 5'h1F);
    expect_at(0, "al_wr0", 1'b1, 5'h08, 5'h08, 1'b1);
    drain();
    run(2);

    if (sbq.size() != 0) chk("sb_leftover", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/joypad_debouncer.md
Name: joypad_debouncer

Overview:
- Conditions the raw 5-bit joypad pins before they reach the CPU data bus: 2-FF synchronizer, per-button debounce counter, and sticky press-event latches.
- Sits directly upstream of the SEL_JOYPAD read-mux leg of the SoC top; the CPU reads clean levels and events through it.
- Exposes an `irq` level so the CPU can be woken on a new button press instead of polling.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive synchronized-sample cycles a new level must hold before it is accepted (10 ms at 25 MHz); legal range 2..2^24-1.
- ACTIVE_LOW, 0, 1 = raw pins read 0 when pressed; inverted at the synchronizer input.

Ports:
- clk  input  1  system clock (same domain as CPU data bus)
- rst_n  input  1  asynchronous active-low reset
- joypad_raw  input  5  raw button pins, asynchronous to clk
- addr  input  1  register select (data_addr[2] from the bus)
- wdata  input  5  write data (data_wdata[4:0])
- wenable  input  1  write strobe, already qualified with SEL_JOYPAD
- rdata  output  32  read data, combinational from registers
- irq  output  1  high while any event bit is set

Behaviour:
- Clock and reset:
  - One clock `clk`; reset `rst_n` is asynchronous, active-low.
  - Reset clears all state: sync FFs, counters, level=0, events=0, irq=0, rdata=0 (addr=0).
- Button order: bit 0 right, 1 left, 2 up, 3 down, 4 action.
- Synchronizer: `p = joypad_raw ^ {5{ACTIVE_LOW}}` passes through two flops; output `s[i]`. No logic between the two flops.
- Per-button debounce (independent for each i):
  - If `s[i] == level[i]`: cnt[i] <= 0.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: level[i] <= s[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`; it never wraps, because it is reset on acceptance.
  - A glitch shorter than DEBOUNCE_CYCLES restarts the count from 0 and is never accepted.
- Latency: a raw edge held stable is reflected in `level` exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- Events:
  - event[i] is set on the same edge level[i] goes 0->1.
  - Releases (1->0) set nothing.
  - event[i] stays set until cleared.
- Register map (reads are side-effect free):
  - addr=0: rdata = {27'b0, level}; writes are ignored.
  - addr=1: rdata = {27'b0, event}.
  - addr=1 write with wenable=1: event <= event & ~wdata (write-1-to-clear).
- Simultaneous clear and new press on the same bit and edge: set wins, so the bit stays 1.
- irq = |event, registered (changes on the same edge as event).
- Reset asserted mid-count: counters discard progress; after release, a held button needs the full 2+DEBOUNCE_CYCLES again and produces a fresh event.
- Button already held at reset release: it is accepted after the debounce delay and raises an event. This is intentional: the firmware sees held buttons.

Decomposition:
- Shared package `joypad_pkg`:
  - button index constants JOY_RIGHT..JOY_ACTION (0..4)
  - register offsets JOY_REG_LEVEL=0, JOY_REG_EVENT=1
  - JOY_WIDTH=5
- One natural sub-module, `debounce_cell`:
  - One-bit debouncer: sync pair, counter, level flop, rise pulse output.
  - Parameterized by DEBOUNCE_CYCLES; instantiated 5 times via generate.
- Event latches, register mux and irq stay in `joypad_debouncer`.

Test Plan (sim with DEBOUNCE_CYCLES=4, ACTIVE_LOW=0):
- Reset behaviour: assert rst_n=0 mid-run with joypad_raw=5'h1F -> all outputs 0 immediately, without waiting for a clock edge; after release, level reads 5'h1F exactly 6 edges later, and event=5'h1F with irq=1 on the same edge.
- Glitch rejection: raw bit 2 pulsed high for 3 cycles, then low -> level and event stay 0 throughout, irq stays 0.
- Press and clear: raw bit 4 high and held -> level=5'h10 after 6 edges, event=5'h10, irq=1; write addr=1 wdata=5'h10 -> next edge event=0, irq=0, level still 5'h10; release -> level=0 after 6 edges, no event.
- Clear/set collision: time a write-1-to-clear of bit 0 on the exact edge level[0] rises -> event[0]=1 afterwards. Separately, clearing bit 1 while bit 0 stays pending -> event=5'h01, irq=1.
- ACTIVE_LOW=1 instance: raw=5'h1F idle -> level stays 0; raw bit 3 driven 0 and held -> level=5'h08 after 6 edges; a write to addr=0 has no effect on any register.
